// File: rtl/dwt_dec_stage.sv
// One level of a wavelet decomposition: 8-tap low/high-pass FIR on a
// multi-lane sample stream, decimated by two, with optional rounding/saturation.
module dwt_dec_stage #(
  parameter int                  LANES     = 4,
  parameter int                  DATA_W    = 48,
  parameter int                  COEF_W    = 25,
  parameter int                  COEF_FRAC = 23,
  parameter logic [8*COEF_W-1:0] DEC_LO    = '0,
  parameter logic [8*COEF_W-1:0] DEC_HI    = '0,
  parameter int                  ROUND_EN  = 0,
  parameter int                  SAT_EN    = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic                           din_valid,
  input  logic [LANES*DATA_W-1:0]        din,
  output logic                           dout_valid,
  output logic [(LANES/2)*DATA_W-1:0]    approx,
  output logic [(LANES/2)*DATA_W-1:0]    detail,
  output logic                           ovf
);

  localparam int HALF   = LANES / 2;
  localparam int NEXT   = LANES + 7;
  localparam int NWIN   = LANES + 6;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + 3;
  localparam logic [3:0] WARM = 4'((7 + LANES - 1) / LANES);
  localparam logic signed [ACC_W:0] RND_K = {{ACC_W{1'b0}}, 1'b1} << (COEF_FRAC - 1);
  localparam logic signed [ACC_W:0] MAX_K = {{(ACC_W - DATA_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] MIN_K = {{(ACC_W - DATA_W + 2){1'b1}}, {(DATA_W - 1){1'b0}}};

  function automatic logic signed [COEF_W-1:0] tap(input logic [8*COEF_W-1:0] taps, input int k);
    return taps[k*COEF_W +: COEF_W];
  endfunction

  // Returns {clamped, value}: optional half-up rounding, shift back to sample scale, clamp or wrap.
  function automatic logic [DATA_W:0] scale(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W:0] r;
    logic signed [ACC_W:0] s;
    logic [DATA_W:0]       res;
    r = {acc[ACC_W-1], acc};
    if (ROUND_EN != 0) begin
      r = r + RND_K;
    end else begin
      r = r;
    end
    s = r >>> COEF_FRAC;
    if ((SAT_EN != 0) && (s > MAX_K)) begin
      res = {1'b1, MAX_K[DATA_W-1:0]};
    end else if ((SAT_EN != 0) && (s < MIN_K)) begin
      res = {1'b1, MIN_K[DATA_W-1:0]};
    end else begin
      res = {1'b0, s[DATA_W-1:0]};
    end
    return res;
  endfunction

  logic signed [DATA_W-1:0] hist_r [7];
  logic signed [DATA_W-1:0] ext_s [NEXT];
  logic signed [DATA_W-1:0] win_r [NWIN];
  logic [3:0]               warm_r;
  logic                     v_win_r;
  logic                     v_mul_r;
  logic                     v_sum_r;
  logic signed [PROD_W-1:0] prod_lo_r [HALF][8];
  logic signed [PROD_W-1:0] prod_hi_r [HALF][8];
  logic signed [ACC_W-1:0]  sum_lo_s [HALF];
  logic signed [ACC_W-1:0]  sum_hi_s [HALF];
  logic signed [ACC_W-1:0]  sum_lo_r [HALF];
  logic signed [ACC_W-1:0]  sum_hi_r [HALF];
  logic [DATA_W:0]          res_lo_s [HALF];
  logic [DATA_W:0]          res_hi_s [HALF];
  logic                     ovf_s;

  // Extended window: 7 history samples followed by the incoming lanes (oldest first).
  always_comb begin
    for (int m = 0; m < 7; m++) ext_s[m] = hist_r[m];
    for (int i = 0; i < LANES; i++) ext_s[7+i] = din[i*DATA_W +: DATA_W];
  end

  // History, warm-up and valid pipeline; clr zeroes history and kills in-flight beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < 7; m++) hist_r[m] <= '0;
      warm_r  <= 4'd0;
      v_win_r <= 1'b0;
      v_mul_r <= 1'b0;
      v_sum_r <= 1'b0;
    end else if (clr) begin
      for (int m = 0; m < 7; m++) hist_r[m] <= '0;
      warm_r  <= 4'd0;
      v_win_r <= 1'b0;
      v_mul_r <= 1'b0;
      v_sum_r <= 1'b0;
    end else begin
      v_mul_r <= v_win_r;
      v_sum_r <= v_mul_r;
      if (din_valid) begin
        for (int m = 0; m < 7; m++) hist_r[m] <= ext_s[LANES+m];
        if (warm_r < WARM) begin
          warm_r  <= warm_r + 4'd1;
          v_win_r <= 1'b0;
        end else begin
          v_win_r <= 1'b1;
        end
      end else begin
        v_win_r <= 1'b0;
      end
    end
  end

  // Window capture, tap products and the 8-term sums; data is free-running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < NWIN; m++) win_r[m] <= '0;
      for (int j = 0; j < HALF; j++) begin
        for (int k = 0; k < 8; k++) begin
          prod_lo_r[j][k] <= '0;
          prod_hi_r[j][k] <= '0;
        end
        sum_lo_r[j] <= '0;
        sum_hi_r[j] <= '0;
      end
    end else begin
      if (din_valid) begin
        for (int m = 0; m < NWIN; m++) win_r[m] <= ext_s[m];
      end
      for (int j = 0; j < HALF; j++) begin
        for (int k = 0; k < 8; k++) begin
          prod_lo_r[j][k] <= PROD_W'(tap(DEC_LO, k)) * PROD_W'(win_r[7+2*j-k]);
          prod_hi_r[j][k] <= PROD_W'(tap(DEC_HI, k)) * PROD_W'(win_r[7+2*j-k]);
        end
        sum_lo_r[j] <= sum_lo_s[j];
        sum_hi_r[j] <= sum_hi_s[j];
      end
    end
  end

  // Accumulate products and scale the registered sums.
  always_comb begin
    ovf_s = 1'b0;
    for (int j = 0; j < HALF; j++) begin
      sum_lo_s[j] = '0;
      sum_hi_s[j] = '0;
      for (int k = 0; k < 8; k++) begin
        sum_lo_s[j] = sum_lo_s[j] + ACC_W'(prod_lo_r[j][k]);
        sum_hi_s[j] = sum_hi_s[j] + ACC_W'(prod_hi_r[j][k]);
      end
      res_lo_s[j] = scale(sum_lo_r[j]);
      res_hi_s[j] = scale(sum_hi_r[j]);
      ovf_s = ovf_s | res_lo_s[j][DATA_W] | res_hi_s[j][DATA_W];
    end
  end

  // Output registers hold their value between valid beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_valid <= 1'b0;
      approx     <= '0;
      detail     <= '0;
      ovf        <= 1'b0;
    end else begin
      dout_valid <= v_sum_r;
      if (v_sum_r) begin
        for (int j = 0; j < HALF; j++) begin
          approx[j*DATA_W +: DATA_W] <= res_lo_s[j][DATA_W-1:0];
          detail[j*DATA_W +: DATA_W] <= res_hi_s[j][DATA_W-1:0];
        end
        ovf <= ovf_s;
      end else begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dwt_dec_stage.sv
// Bench for dwt_dec_stage: three parameterisations share one stimulus stream and
// are scored against a stream-level FIR model plus directed checks.
module tb_dwt_dec_stage;

  localparam int L  = 4;
  localparam int DW = 48;
  localparam int HW = 96;
  localparam int WU = 2;

  typedef struct packed {logic [31:0] tag; logic ov; logic [HW-1:0] dt; logic [HW-1:0] ap;} exp_t;
  typedef struct packed {logic ov; logic [HW-1:0] dt; logic [HW-1:0] ap;} cap_t;

  // dut0: taps 1..8 / -1..-8, trunc, sat; dut1: lo h0=0.5, hi h0=h1=1, trunc, wrap; dut2: same taps, round, sat
  function automatic int tap_val(input int g, input int band, input int k);
    int v;
    if (g == 0) v = (k + 1) << 23;
    else if (band == 0) v = (k == 0) ? (1 << 22) : 0;
    else v = (k < 2) ? (1 << 23) : 0;
    if (g == 0 && band == 1) v = -v;
    return v;
  endfunction

  function automatic logic [223:0] pack_taps(input int g, input int band, input int cw);
    logic [223:0] r;
    logic [31:0]  t;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      t = tap_val(g, band, k);
      for (int b = 0; b < cw; b++) r[k*cw+b] = t[b];
    end
    return r;
  endfunction

  localparam logic [223:0] LO_P [3] = '{pack_taps(0, 0, 28), pack_taps(1, 0, 25), pack_taps(2, 0, 25)};
  localparam logic [223:0] HI_P [3] = '{pack_taps(0, 1, 28), pack_taps(1, 1, 25), pack_taps(2, 1, 25)};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          din_valid = 1'b0;
  logic [L*DW-1:0] din = '0;
  logic          dv [3];
  logic [HW-1:0] ap [3];
  logic [HW-1:0] dt [3];
  logic          ov [3];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic signed [DW-1:0] xs [$];
  exp_t exp_q [3][$];
  cap_t cap_q [3][$];
  exp_t mon_x;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CW = (g == 0) ? 28 : 25;
    dwt_dec_stage #(
      .LANES(L), .DATA_W(DW), .COEF_W(CW), .COEF_FRAC(23),
      .DEC_LO(LO_P[g][8*CW-1:0]), .DEC_HI(HI_P[g][8*CW-1:0]),
      .ROUND_EN((g == 2) ? 1 : 0), .SAT_EN((g == 1) ? 0 : 1)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .din_valid(din_valid), .din(din),
      .dout_valid(dv[g]), .approx(ap[g]), .detail(dt[g]), .ovf(ov[g])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // y[j] of stream beat b = sum h[k]*x[b*L+2j-k], then round/shift/clamp by plain arithmetic
  function automatic logic [DW:0] ref_lane(input int g, input int band, input int b, input int j);
    logic signed [79:0] acc, xv, tv, s, mx, mn;
    int idx;
    acc = '0;
    mx = (80'sd1 <<< 47) - 80'sd1;
    mn = -(80'sd1 <<< 47);
    for (int k = 0; k < 8; k++) begin
      idx = b * L + 2 * j - k;
      if (idx >= 0) xv = xs[idx];
      else xv = '0;
      tv = tap_val(g, band, k);
      acc = acc + xv * tv;
    end
    if (g == 2) acc = acc + (80'sd1 <<< 22);
    s = acc >>> 23;
    if (g != 1 && s > mx) return {1'b1, mx[DW-1:0]};
    if (g != 1 && s < mn) return {1'b1, mn[DW-1:0]};
    return {1'b0, s[DW-1:0]};
  endfunction

  task automatic model_step(input logic v, input logic [L*DW-1:0] d, input logic c, input int e);
    exp_t x;
    logic [DW:0] lo, hi;
    int b;
    if (c) begin
      xs.delete();
      for (int g = 0; g < 3; g++)
        while (exp_q[g].size() > 0 && int'(exp_q[g][exp_q[g].size()-1].tag) >= e - 2)
          void'(exp_q[g].pop_back());
    end else if (v) begin
      b = xs.size() / L;
      for (int i = 0; i < L; i++) xs.push_back(d[i*DW +: DW]);
      if (b >= WU) begin
        for (int g = 0; g < 3; g++) begin
          x = '0;
          x.tag = 32'(e);
          for (int j = 0; j < L / 2; j++) begin
            lo = ref_lane(g, 0, b, j);
            hi = ref_lane(g, 1, b, j);
            x.ap[j*DW +: DW] = lo[DW-1:0];
            x.dt[j*DW +: DW] = hi[DW-1:0];
            x.ov = x.ov | lo[DW] | hi[DW];
          end
          exp_q[g].push_back(x);
        end
      end
    end
  endtask

  task automatic drive(input logic v, input logic [L*DW-1:0] d, input logic c);
    din_valid = v;
    din = d;
    clr = c;
    model_step(v, d, c, cyc + 1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [L*DW-1:0] rnd_beat();
    logic [L*DW-1:0] r;
    for (int i = 0; i < L; i++) r[i*DW +: DW] = {16'($urandom), $urandom};
    return r;
  endfunction

  function automatic logic [HW-1:0] pair(input int l0, input int l1);
    logic signed [DW-1:0] a, b;
    a = l0 * 8388608;
    b = l1 * 8388608;
    return {b, a};
  endfunction

  // Scoreboard: every dout_valid beat must match the next modelled beat.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int g = 0; g < 3; g++) begin
        if (dv[g]) begin
          cap_q[g].push_back({ov[g], dt[g], ap[g]});
          total++;
          if (exp_q[g].size() == 0) begin
            bad++;
            $display("FAIL scoreboard_spurious dut%0d: dout_valid=1, required no output", g);
          end else begin
            mon_x = exp_q[g].pop_front();
            if ({ov[g], dt[g], ap[g]} !== {mon_x.ov, mon_x.dt, mon_x.ap}) begin
              bad++;
              $display("FAIL scoreboard dut%0d edge%0d: got ap=%h dt=%h ovf=%b, required ap=%h dt=%h ovf=%b",
                       g, mon_x.tag, ap[g], dt[g], ov[g], mon_x.ap, mon_x.dt, mon_x.ov);
            end
          end
        end
      end
    end
  end

  task automatic test_reset();
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0);
    for (int g = 0; g < 3; g++) begin
      total += 4;
      if (dv[g] !== 1'b0) begin bad++; $display("FAIL reset_valid dut%0d: got %b required 0", g, dv[g]); end
      if (ap[g] !== '0) begin bad++; $display("FAIL reset_approx dut%0d: got %h required 0", g, ap[g]); end
      if (dt[g] !== '0) begin bad++; $display("FAIL reset_detail dut%0d: got %h required 0", g, dt[g]); end
      if (ov[g] !== 1'b0) begin bad++; $display("FAIL reset_ovf dut%0d: got %b required 0", g, ov[g]); end
    end
    rst_n = 1'b1;
    drive(1'b0, rnd_beat(), 1'b0);
    for (int g = 0; g < 3; g++) begin
      total++;
      if (dv[g] !== 1'b0) begin bad++; $display("FAIL reset_idle dut%0d: got %b required 0", g, dv[g]); end
    end
  endtask

  task automatic test_latency();
    for (int k = 0; k < 9; k++) begin
      drive(k < 3, rnd_beat(), 1'b0);
      total++;
      if (dv[0] !== (k == 5)) begin
        bad++;
        $display("FAIL latency edge%0d: dout_valid got %b required %b", k, dv[0], (k == 5));
      end
    end
  endtask

  task automatic test_impulse();
    logic [L*DW-1:0] imp;
    imp = '0;
    imp[DW-1:0] = 48'd1 << 23;
    drive(1'b0, '0, 1'b1);
    drive(1'b1, '0, 1'b0);
    drive(1'b1, '0, 1'b0);
    drive(1'b1, imp, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, '0, 1'b0);
      if (k >= 3) begin
        total += 3;
        if (dv[0] !== 1'b1) begin bad++; $display("FAIL impulse_valid step%0d: got %b required 1", k, dv[0]); end
        if (ap[0] !== ((k == 3) ? pair(1, 3) : (k == 4) ? pair(5, 7) : pair(0, 0))) begin
          bad++; $display("FAIL impulse_approx step%0d: got %h", k, ap[0]);
        end
        if (dt[0] !== ((k == 3) ? pair(-1, -3) : (k == 4) ? pair(-5, -7) : pair(0, 0))) begin
          bad++; $display("FAIL impulse_detail step%0d: got %h", k, dt[0]);
        end
      end
    end
  endtask

  task automatic test_rounding();
    logic [L*DW-1:0] b;
    b = '0;
    b[0 +: DW] = 48'd1;
    b[2*DW +: DW] = 48'hFFFF_FFFF_FFFF;
    drive(1'b0, '0, 1'b1);
    drive(1'b1, '0, 1'b0);
    drive(1'b1, '0, 1'b0);
    drive(1'b1, b, 1'b0);
    for (int k = 0; k < 3; k++) drive(1'b0, '0, 1'b0);
    total += 4;
    if (dv[1] !== 1'b1) begin bad++; $display("FAIL round_valid: got %b required 1", dv[1]); end
    if (ap[1] !== {48'hFFFF_FFFF_FFFF, 48'h0}) begin
      bad++; $display("FAIL round_trunc: got %h required %h", ap[1], {48'hFFFF_FFFF_FFFF, 48'h0});
    end
    if (ap[2] !== {48'h0, 48'h1}) begin
      bad++; $display("FAIL round_half_up: got %h required %h", ap[2], {48'h0, 48'h1});
    end
    if (dt[1] !== {48'hFFFF_FFFF_FFFF, 48'h1}) begin
      bad++; $display("FAIL round_detail: got %h required %h", dt[1], {48'hFFFF_FFFF_FFFF, 48'h1});
    end
  endtask

  task automatic test_saturation();
    drive(1'b0, '0, 1'b1);
    for (int k = 0; k < 6; k++) drive(k < 3, {L{48'h7FFF_FFFF_FFFF}}, 1'b0);
    total += 5;
    if (dv[1] !== 1'b1) begin bad++; $display("FAIL sat_valid: got %b required 1", dv[1]); end
    if (dt[1] !== {2{48'hFFFF_FFFF_FFFE}}) begin
      bad++; $display("FAIL sat_wrap: got %h required %h", dt[1], {2{48'hFFFF_FFFF_FFFE}});
    end
    if (ov[1] !== 1'b0) begin bad++; $display("FAIL sat_wrap_ovf: got %b required 0", ov[1]); end
    if (dt[2] !== {2{48'h7FFF_FFFF_FFFF}}) begin
      bad++; $display("FAIL sat_clamp: got %h required %h", dt[2], {2{48'h7FFF_FFFF_FFFF}});
    end
    if (ov[2] !== 1'b1) begin bad++; $display("FAIL sat_clamp_ovf: got %b required 1", ov[2]); end
    drive(1'b0, '0, 1'b0);
    total++;
    if (ov[2] !== 1'b0) begin bad++; $display("FAIL sat_ovf_pulse: got %b required 0", ov[2]); end
  endtask

  task automatic test_gapped();
    logic [L*DW-1:0] beats [200];
    cap_t gapless [3][$];
    for (int i = 0; i < 200; i++) beats[i] = rnd_beat();
    drive(1'b0, '0, 1'b1);
    for (int g = 0; g < 3; g++) cap_q[g].delete();
    for (int i = 0; i < 200; i++) drive(1'b1, beats[i], 1'b0);
    for (int k = 0; k < 6; k++) drive(1'b0, rnd_beat(), 1'b0);
    for (int g = 0; g < 3; g++) gapless[g] = cap_q[g];
    drive(1'b0, '0, 1'b1);
    for (int g = 0; g < 3; g++) cap_q[g].delete();
    for (int i = 0; i < 200; i++) begin
      for (int n = 0; n < 40 && $urandom_range(99) >= 30; n++) drive(1'b0, rnd_beat(), 1'b0);
      drive(1'b1, beats[i], 1'b0);
    end
    for (int k = 0; k < 6; k++) drive(1'b0, rnd_beat(), 1'b0);
    for (int g = 0; g < 3; g++) begin
      total += 2;
      if (gapless[g].size() !== 198) begin
        bad++; $display("FAIL gapless_count dut%0d: got %0d required 198", g, gapless[g].size());
      end
      if (cap_q[g].size() !== gapless[g].size()) begin
        bad++; $display("FAIL gapped_count dut%0d: got %0d required %0d", g, cap_q[g].size(), gapless[g].size());
      end else begin
        for (int i = 0; i < cap_q[g].size(); i++) begin
          total++;
          if (cap_q[g][i] !== gapless[g][i]) begin
            bad++; $display("FAIL gapped_beat dut%0d #%0d: got %h required %h", g, i, cap_q[g][i], gapless[g][i]);
          end
        end
      end
    end
  endtask

  task automatic test_clr();
    logic [DW:0] l0, l1;
    logic [HW-1:0] want;
    drive(1'b0, '0, 1'b1);
    for (int k = 0; k < 6; k++) drive(1'b1, rnd_beat(), 1'b0);
    for (int k = 0; k < 4; k++) drive(1'b0, '0, 1'b0);
    want = '0;
    for (int k = 0; k < 10; k++) begin
      drive(k < 6, rnd_beat(), k == 2);
      if (k == 5) begin
        l0 = ref_lane(0, 0, 2, 0);
        l1 = ref_lane(0, 0, 2, 1);
        want = {l1[DW-1:0], l0[DW-1:0]};
      end
      total++;
      if (dv[0] !== (k == 8)) begin
        bad++; $display("FAIL clr_valid edge%0d: got %b required %b", k, dv[0], (k == 8));
      end
      if (k == 8) begin
        total++;
        if (ap[0] !== want) begin bad++; $display("FAIL clr_first_out: got %h required %h", ap[0], want); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_impulse();
    test_rounding();
    test_saturation();
    test_gapped();
    test_clr();
    for (int g = 0; g < 3; g++) begin
      total++;
      if (exp_q[g].size() != 0) begin
        bad++; $display("FAIL missing_outputs dut%0d: got %0d pending required 0", g, exp_q[g].size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
